i2cs_mailbox_ctrl: RTL and testbench
====================================

// Module: i2cs_mailbox_ctrl
// PURPOSE
//  Arbitrates and sequences access to the I2C slave's register space, which is
//  shared between the I2C peripheral register port and the host-side APB
//  register port.
//  Provides 4 shared scratch registers and two byte mailbox FIFOs:
//  I2C->host (i2h) and host->I2C (h2i). Status, sticky flags and interrupts
//  are generated here. Sits between i2c_peripheral_interface and the APB wrapper.
// PARAMETERS
//  FIFO_DEPTH  8  entries per mailbox FIFO; power of 2, >= 2
//  WATERMARK   4  i2h count at or above which the host irq source asserts; 1..FIFO_DEPTH
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, asynchronous, active-high
//  i2c_addr_i      in   8   register address latched by I2C interface
//  i2c_wdata_i     in   8   write byte; valid when i2c_wren_i=1
//  i2c_wren_i      in   1   1-cycle write strobe
//  i2c_rdata_o     out  8   read byte, combinational from i2c_addr_i
//  i2c_rdone_i     in   1   1-cycle pulse after each read byte is shifted out
//  host_req_i      in   1   host access request
//  host_we_i       in   1   1=write, 0=read
//  host_addr_i     in   3   host word index
//  host_wdata_i    in   8   host write byte
//  host_rdata_o    out  8   host read byte; valid when host_ready_o=1
//  host_ready_o    out  1   access completes this cycle
//  host_irq_o      out  1   level interrupt to host
//  i2c_irq_o       out  1   level attention flag to external I2C master (h2i not empty)
// BEHAVIOUR
//  Reset: FIFOs empty; scratch=0; stickies=0; irq_en=0; all outputs 0 except host_ready_o=0.
//  I2C map:
//   0x00-03  scratch R/W
//   0x10  W: push i2h
//   0x11  R: i2h free count
//   0x20  R: h2i head
//   0x21  R: h2i count
//   0x30  status {4'b0, h2i_udf, i2h_ovf, i2h_full, h2i_nempty}; W1C bits[3:2]
//   Other addresses: read 0x00, writes ignored.
//  Host map:
//   0-3  scratch
//   4  W: push h2i
//   5  R: pop i2h (returns head)
//   6  R: {i2h_cnt[3:0], h2i_cnt[3:0]}, counts saturated at 15
//   7  irq_en {5'b0, flush, en_sticky, en_wm}
//       flush: self-clearing; empties both FIFOs in 1 cycle
//  I2C read pop: on i2c_rdone_i with addr 0x20 and h2i non-empty, pop.
//   i2c_rdata_o shows the new head the next cycle.
//   Empty head reads 0xFF; rdone while empty sets h2i_udf (sticky).
//  I2C push when full: drop the byte, set i2h_ovf (sticky).
//  Host push when full: drop the byte. Host pop when empty: return 0xFF, no state change.
//  Host handshake: host_ready_o=1 in the same cycle as host_req_i (combinational).
//   Exception: stall 1 cycle (ready=0) when i2c_wren_i writes the same scratch
//   index in that cycle. The I2C write lands first; the host write overwrites
//   it on the next cycle.
//   Host read data is registered into host_rdata_o and is valid with ready.
//  Simultaneous push+pop on one FIFO: both occur, count unchanged.
//   If full, the push is accepted because a pop frees a slot.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
//  host_irq_o = (en_wm & i2h_cnt>=WATERMARK) | (en_sticky & (i2h_ovf|h2i_udf)); registered, +1 cycle.
//  i2c_irq_o = h2i non-empty, registered.
//  Async reset mid-transaction aborts all pending accesses. No partial writes survive.
// STRUCTURE
//  Package i2cs_mbox_pkg: I2C and host address localparams, status bit indices.
//  Sub-module i2cs_sync_fifo (8-bit, DEPTH param, push/pop/flush, count, full/empty),
//  instanced twice (i2h, h2i). Arbitration, decode and stickies live in this module.
// TESTING
//  I2C write 0x10 with 0xA5,0x5A -> host reads reg5: 0xA5 then 0x5A, then 0xFF; reg6 i2h=0.
//  Host pushes 9 bytes, DEPTH=8 -> ninth byte dropped; 8 rdone pulses at addr 0x20 -> bytes 1..8; 9th rdone sets udf, i2c_irq_o falls.
//  i2c_wren_i to 0x01=0x11 and host write idx1=0x22 same cycle -> ready low 1 cycle; final scratch1=0x22.
//  en_wm=1; 4 I2C pushes -> host_irq_o rises 1 cycle after 4th push; host pop -> falls.
//  Full i2h, push+host pop same cycle -> count stays 8, no ovf; I2C write 0x30=0x0C clears stickies.
//  Assert rst mid-read stream -> FIFOs empty, irqs 0, i2c_rdata_o at 0x20 reads 0xFF.

Source files
------------

// File: rtl/i2cs_mbox_pkg.sv
// Shared constants for the I2C slave mailbox controller: register maps of the
// I2C and host ports, status / irq-enable bit positions and a count helper.
package i2cs_mbox_pkg;

  // I2C register map (8-bit addresses)
  localparam logic [7:0] I2C_I2H_PUSH = 8'h10;
  localparam logic [7:0] I2C_I2H_FREE = 8'h11;
  localparam logic [7:0] I2C_H2I_HEAD = 8'h20;
  localparam logic [7:0] I2C_H2I_CNT  = 8'h21;
  localparam logic [7:0] I2C_STATUS   = 8'h30;

  // Host register map (3-bit word index); 0..3 are the scratch registers
  localparam logic [2:0] HOST_PUSH_H2I = 3'd4;
  localparam logic [2:0] HOST_POP_I2H  = 3'd5;
  localparam logic [2:0] HOST_COUNTS   = 3'd6;
  localparam logic [2:0] HOST_IRQ_EN   = 3'd7;

  // Status register bit positions
  localparam int ST_H2I_NEMPTY = 0;
  localparam int ST_I2H_FULL   = 1;
  localparam int ST_I2H_OVF    = 2;
  localparam int ST_H2I_UDF    = 3;

  // irq_en register bit positions
  localparam int IRQ_EN_WM     = 0;
  localparam int IRQ_EN_STICKY = 1;
  localparam int IRQ_EN_FLUSH  = 2;

  // Value returned when reading the head of an empty FIFO
  localparam logic [7:0] EMPTY_READ = 8'hFF;

  // Clamp a FIFO count into a 4-bit field
  function automatic logic [3:0] sat_nibble(input logic [31:0] cnt);
    if (cnt > 32'd15) begin
      return 4'hF;
    end else begin
      return cnt[3:0];
    end
  endfunction

endpackage

// File: rtl/i2cs_sync_fifo.sv
// Byte-wide synchronous FIFO with flush. A pop on a full FIFO frees the slot
// used by a push in the same cycle; pushes to a full FIFO without a pop and
// pops from an empty FIFO are ignored. Flush takes priority over both.
module i2cs_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Data storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_ok_s & ~flush) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/i2cs_mailbox_ctrl.sv
// Shared register space of the I2C slave: four scratch registers reachable
// from both the I2C and host ports, an I2C->host and a host->I2C byte mailbox,
// sticky error flags and the two interrupt outputs.
module i2cs_mailbox_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int WATERMARK  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i2c_addr_i,
  input  logic [7:0] i2c_wdata_i,
  input  logic       i2c_wren_i,
  output logic [7:0] i2c_rdata_o,
  input  logic       i2c_rdone_i,
  input  logic       host_req_i,
  input  logic       host_we_i,
  input  logic [2:0] host_addr_i,
  input  logic [7:0] host_wdata_i,
  output logic [7:0] host_rdata_o,
  output logic       host_ready_o,
  output logic       host_irq_o,
  output logic       i2c_irq_o
);

  import i2cs_mbox_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    scratch_r [4];
  logic          i2h_ovf_r, h2i_udf_r, en_wm_r, en_sticky_r;
  logic          stall_r, host_irq_r, i2c_irq_r;
  logic [7:0]    host_rdata_r;

  logic          i2h_push_s, i2h_pop_s, i2h_full_s, i2h_empty_s;
  logic          h2i_push_s, h2i_pop_s, h2i_full_s, h2i_empty_s;
  logic [7:0]    i2h_head_s, h2i_head_s;
  logic [CW-1:0] i2h_cnt_s, h2i_cnt_s;
  logic [31:0]   i2h_cnt_ext_s, h2i_cnt_ext_s;
  logic          flush_s;

  logic          i2c_scr_wr_s, host_scr_sel_s, conflict_s;
  logic          host_acc_s, host_wr_s, host_rd_s, irq_en_wr_s, status_wr_s;
  logic          ovf_set_s, udf_set_s, ovf_clr_s, udf_clr_s;
  logic [7:0]    status_s, i2c_rdata_s, host_rd_mux_s;

  // Access decode. A host access to the scratch index the I2C side writes in
  // the same cycle is held off once so the I2C write lands before it.
  assign i2c_scr_wr_s   = i2c_wren_i & (i2c_addr_i[7:2] == 6'h00);
  assign host_scr_sel_s = ~host_addr_i[2];
  assign conflict_s     = host_req_i & host_scr_sel_s & i2c_scr_wr_s &
                          (i2c_addr_i[1:0] == host_addr_i[1:0]) & ~stall_r;
  assign host_acc_s     = host_req_i & ~conflict_s;
  assign host_wr_s      = host_acc_s & host_we_i;
  assign host_rd_s      = host_acc_s & ~host_we_i;
  assign irq_en_wr_s    = host_wr_s & (host_addr_i == HOST_IRQ_EN);
  assign status_wr_s    = i2c_wren_i & (i2c_addr_i == I2C_STATUS);

  assign i2h_push_s = i2c_wren_i & (i2c_addr_i == I2C_I2H_PUSH);
  assign i2h_pop_s  = host_rd_s & (host_addr_i == HOST_POP_I2H);
  assign h2i_push_s = host_wr_s & (host_addr_i == HOST_PUSH_H2I);
  assign h2i_pop_s  = i2c_rdone_i & (i2c_addr_i == I2C_H2I_HEAD);
  assign flush_s    = irq_en_wr_s & host_wdata_i[IRQ_EN_FLUSH];

  // A full FIFO accepts a push only when the host pops in the same cycle
  assign ovf_set_s = i2h_push_s & i2h_full_s & ~i2h_pop_s;
  assign udf_set_s = h2i_pop_s & h2i_empty_s;
  assign ovf_clr_s = status_wr_s & i2c_wdata_i[ST_I2H_OVF];
  assign udf_clr_s = status_wr_s & i2c_wdata_i[ST_H2I_UDF];

  assign i2h_cnt_ext_s = 32'(i2h_cnt_s);
  assign h2i_cnt_ext_s = 32'(h2i_cnt_s);

  i2cs_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_i2h_fifo (
    .clk(clk), .rst(rst), .push(i2h_push_s), .pop(i2h_pop_s), .flush(flush_s),
    .wdata(i2c_wdata_i), .head(i2h_head_s), .count(i2h_cnt_s),
    .full(i2h_full_s), .empty(i2h_empty_s)
  );

  i2cs_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_h2i_fifo (
    .clk(clk), .rst(rst), .push(h2i_push_s), .pop(h2i_pop_s), .flush(flush_s),
    .wdata(host_wdata_i), .head(h2i_head_s), .count(h2i_cnt_s),
    .full(h2i_full_s), .empty(h2i_empty_s)
  );

  // Status byte as seen by the I2C master
  always_comb begin
    status_s                = 8'h00;
    status_s[ST_H2I_NEMPTY] = ~h2i_empty_s;
    status_s[ST_I2H_FULL]   = i2h_full_s;
    status_s[ST_I2H_OVF]    = i2h_ovf_r;
    status_s[ST_H2I_UDF]    = h2i_udf_r;
  end

  // I2C read mux, combinational from the latched I2C address
  always_comb begin
    i2c_rdata_s = 8'h00;
    case (i2c_addr_i)
      8'h00, 8'h01, 8'h02, 8'h03: i2c_rdata_s = scratch_r[i2c_addr_i[1:0]];
      I2C_I2H_FREE:  i2c_rdata_s = 8'(FIFO_DEPTH) - 8'(i2h_cnt_s);
      I2C_H2I_HEAD:  i2c_rdata_s = h2i_empty_s ? EMPTY_READ : h2i_head_s;
      I2C_H2I_CNT:   i2c_rdata_s = 8'(h2i_cnt_s);
      I2C_STATUS:    i2c_rdata_s = status_s;
      default:       i2c_rdata_s = 8'h00;
    endcase
  end

  // Host read mux; the flush bit always reads back as zero
  always_comb begin
    host_rd_mux_s = 8'h00;
    case (host_addr_i)
      3'd0, 3'd1, 3'd2, 3'd3: host_rd_mux_s = scratch_r[host_addr_i[1:0]];
      HOST_POP_I2H:  host_rd_mux_s = i2h_empty_s ? EMPTY_READ : i2h_head_s;
      HOST_COUNTS:   host_rd_mux_s = {sat_nibble(i2h_cnt_ext_s), sat_nibble(h2i_cnt_ext_s)};
      HOST_IRQ_EN:   host_rd_mux_s = {6'b000000, en_sticky_r, en_wm_r};
      default:       host_rd_mux_s = 8'h00;
    endcase
  end

  // Scratch registers: the I2C write is applied first so a host write to the same index wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) scratch_r[i] <= 8'h00;
    end else begin
      if (i2c_scr_wr_s) scratch_r[i2c_addr_i[1:0]] <= i2c_wdata_i;
      if (host_wr_s & host_scr_sel_s) scratch_r[host_addr_i[1:0]] <= host_wdata_i;
    end
  end

  // Sticky flags (set wins over a simultaneous W1C), irq enables and the one-shot stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i2h_ovf_r   <= 1'b0;
      h2i_udf_r   <= 1'b0;
      en_wm_r     <= 1'b0;
      en_sticky_r <= 1'b0;
      stall_r     <= 1'b0;
    end else begin
      i2h_ovf_r <= ovf_set_s | (i2h_ovf_r & ~ovf_clr_s);
      h2i_udf_r <= udf_set_s | (h2i_udf_r & ~udf_clr_s);
      stall_r   <= conflict_s;
      if (irq_en_wr_s) begin
        en_wm_r     <= host_wdata_i[IRQ_EN_WM];
        en_sticky_r <= host_wdata_i[IRQ_EN_STICKY];
      end
    end
  end

  // Registered host read data (captured at the edge closing the ready cycle) and interrupts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rdata_r <= 8'h00;
      host_irq_r   <= 1'b0;
      i2c_irq_r    <= 1'b0;
    end else begin
      if (host_rd_s) host_rdata_r <= host_rd_mux_s;
      host_irq_r <= (en_wm_r & (i2h_cnt_ext_s >= 32'(WATERMARK))) |
                    (en_sticky_r & (i2h_ovf_r | h2i_udf_r));
      i2c_irq_r  <= ~h2i_empty_s;
    end
  end

  assign i2c_rdata_o  = i2c_rdata_s;
  assign host_rdata_o = host_rdata_r;
  assign host_ready_o = host_acc_s;
  assign host_irq_o   = host_irq_r;
  assign i2c_irq_o    = i2c_irq_r;

endmodule

// File: tb/tb_i2cs_mailbox_ctrl.sv
// Scoreboard bench for i2cs_mailbox_ctrl. Stimulus pushes expected responses;
// the negedge monitor pops and compares whenever a host read completes or a
// probe of an I2C-side output is requested.
`timescale 1ns/1ps
module tb_i2cs_mailbox_ctrl;

  localparam int SRC_HOST = 0;
  localparam int SRC_I2C  = 1;
  localparam int SRC_HIRQ = 2;
  localparam int SRC_IIRQ = 3;
  localparam int SRC_RDY  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i2c_addr_i = 8'h00;
  logic [7:0] i2c_wdata_i = 8'h00;
  logic       i2c_wren_i = 1'b0;
  logic [7:0] i2c_rdata_o;
  logic       i2c_rdone_i = 1'b0;
  logic       host_req_i = 1'b0;
  logic       host_we_i = 1'b0;
  logic [2:0] host_addr_i = 3'd0;
  logic [7:0] host_wdata_i = 8'h00;
  logic [7:0] host_rdata_o;
  logic       host_ready_o;
  logic       host_irq_o;
  logic       i2c_irq_o;

  typedef struct {
    int         src;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic probe_v = 1'b0;
  int   probe_src = 0;
  logic rd_pend = 1'b0;

  i2cs_mailbox_ctrl #(.FIFO_DEPTH(8), .WATERMARK(4)) dut (
    .clk(clk), .rst(rst),
    .i2c_addr_i(i2c_addr_i), .i2c_wdata_i(i2c_wdata_i), .i2c_wren_i(i2c_wren_i),
    .i2c_rdata_o(i2c_rdata_o), .i2c_rdone_i(i2c_rdone_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_rdata_o(host_rdata_o),
    .host_ready_o(host_ready_o), .host_irq_o(host_irq_o), .i2c_irq_o(i2c_irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_out(input int src, input logic [7:0] act);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_output: src=%0d got=%h, nothing expected", src, act);
    end else begin
      e = exp_q.pop_front();
      if (e.src != src || act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h (src %0d), expected %h (src %0d)", e.name, act, src, e.val, e.src);
      end
    end
  endtask

  // Monitor: completed host reads first, then any requested probe
  always @(negedge clk) begin
    if (rd_pend) check_out(SRC_HOST, host_rdata_o);
    if (probe_v) begin
      case (probe_src)
        SRC_I2C:  check_out(SRC_I2C, i2c_rdata_o);
        SRC_HIRQ: check_out(SRC_HIRQ, {7'b0000000, host_irq_o});
        SRC_IIRQ: check_out(SRC_IIRQ, {7'b0000000, i2c_irq_o});
        SRC_RDY:  check_out(SRC_RDY, {7'b0000000, host_ready_o});
        default:  check_out(-1, 8'h00);
      endcase
    end
    rd_pend <= host_req_i & host_ready_o & ~host_we_i & ~rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    probe_v = 1'b0;
  endtask

  task automatic expect_out(input int src, input logic [7:0] val, input string name);
    exp_t e;
    e.src = src;
    e.val = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Sample one output in the current cycle, then advance one cycle
  task automatic probe(input int src, input logic [7:0] val, input string name);
    expect_out(src, val, name);
    probe_src = src;
    probe_v = 1'b1;
    tick();
  endtask

  task automatic i2c_wr(input logic [7:0] a, input logic [7:0] d);
    i2c_addr_i = a;
    i2c_wdata_i = d;
    i2c_wren_i = 1'b1;
    tick();
    i2c_wren_i = 1'b0;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    host_req_i = 1'b1;
    host_we_i = 1'b1;
    host_addr_i = a;
    host_wdata_i = d;
    tick();
    host_req_i = 1'b0;
    host_we_i = 1'b0;
  endtask

  task automatic host_rd(input logic [2:0] a, input logic [7:0] exp_v, input string name);
    expect_out(SRC_HOST, exp_v, name);
    host_req_i = 1'b1;
    host_we_i = 1'b0;
    host_addr_i = a;
    tick();
    host_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    probe(SRC_HIRQ, 8'h00, "rst_host_irq");
    probe(SRC_IIRQ, 8'h00, "rst_i2c_irq");
    probe(SRC_RDY, 8'h00, "rst_ready");
    i2c_addr_i = 8'h20;
    probe(SRC_I2C, 8'hFF, "rst_h2i_head");
    i2c_addr_i = 8'h11;
    probe(SRC_I2C, 8'h08, "rst_i2h_free");
    host_rd(3'd0, 8'h00, "rst_scratch0");
    host_rd(3'd6, 8'h00, "rst_counts");

    // I2C pushes, host pops in order, then empty pop
    i2c_wr(8'h10, 8'hA5);
    i2c_wr(8'h10, 8'h5A);
    i2c_addr_i = 8'h11;
    probe(SRC_I2C, 8'h06, "i2h_free_after_2");
    host_rd(3'd5, 8'hA5, "pop1");
    host_rd(3'd5, 8'h5A, "pop2");
    host_rd(3'd5, 8'hFF, "pop_empty");
    host_rd(3'd6, 8'h00, "counts_after_pops");

    // Host pushes 9 into an 8-deep FIFO; I2C drains with rdone pulses
    for (int k = 1; k <= 9; k++) host_wr(3'd4, 8'(k));
    host_rd(3'd6, 8'h08, "h2i_count_full");
    probe(SRC_IIRQ, 8'h01, "i2c_irq_set");
    i2c_addr_i = 8'h20;
    for (int k = 1; k <= 8; k++) begin
      i2c_rdone_i = 1'b1;
      probe(SRC_I2C, 8'(k), "h2i_head_seq");
      i2c_rdone_i = 1'b0;
    end
    i2c_rdone_i = 1'b1;
    probe(SRC_I2C, 8'hFF, "h2i_head_empty");
    i2c_rdone_i = 1'b0;
    probe(SRC_IIRQ, 8'h00, "i2c_irq_fell");
    i2c_addr_i = 8'h30;
    probe(SRC_I2C, 8'h08, "status_udf");
    i2c_wr(8'h30, 8'h0C);
    probe(SRC_I2C, 8'h00, "status_cleared");

    // Same-cycle scratch write collision
    i2c_addr_i = 8'h01;
    i2c_wdata_i = 8'h11;
    i2c_wren_i = 1'b1;
    host_req_i = 1'b1;
    host_we_i = 1'b1;
    host_addr_i = 3'd1;
    host_wdata_i = 8'h22;
    probe(SRC_RDY, 8'h00, "stall_ready_low");
    i2c_wren_i = 1'b0;
    probe(SRC_RDY, 8'h01, "stall_ready_high");
    host_req_i = 1'b0;
    host_we_i = 1'b0;
    probe(SRC_I2C, 8'h22, "scratch1_i2c_view");
    host_rd(3'd1, 8'h22, "scratch1_host_view");

    // Watermark interrupt
    host_wr(3'd7, 8'h01);
    for (int k = 0; k < 4; k++) i2c_wr(8'h10, 8'h10 + 8'(k));
    probe(SRC_HIRQ, 8'h00, "wm_irq_delay");
    probe(SRC_HIRQ, 8'h01, "wm_irq_rise");
    host_rd(3'd5, 8'h10, "wm_pop");
    probe(SRC_HIRQ, 8'h01, "wm_irq_hold");
    probe(SRC_HIRQ, 8'h00, "wm_irq_fall");

    // Flush, fill i2h, push+pop while full, overflow and W1C
    host_wr(3'd7, 8'h04);
    i2c_addr_i = 8'h11;
    probe(SRC_I2C, 8'h08, "free_after_flush");
    host_rd(3'd7, 8'h00, "irq_en_readback");
    for (int k = 0; k < 8; k++) i2c_wr(8'h10, 8'h80 + 8'(k));
    i2c_addr_i = 8'h30;
    probe(SRC_I2C, 8'h02, "status_full");
    i2c_addr_i = 8'h10;
    i2c_wdata_i = 8'hEE;
    i2c_wren_i = 1'b1;
    host_rd(3'd5, 8'h80, "pop_while_push_full");
    i2c_wren_i = 1'b0;
    host_rd(3'd6, 8'h80, "count_stays_full");
    i2c_addr_i = 8'h30;
    probe(SRC_I2C, 8'h02, "no_ovf");
    i2c_wr(8'h10, 8'hEF);
    i2c_addr_i = 8'h30;
    probe(SRC_I2C, 8'h06, "ovf_sticky");
    host_wr(3'd7, 8'h02);
    tick();
    probe(SRC_HIRQ, 8'h01, "sticky_irq");
    i2c_wr(8'h30, 8'h0C);
    probe(SRC_I2C, 8'h02, "ovf_cleared");
    probe(SRC_HIRQ, 8'h00, "sticky_irq_cleared");
    host_rd(3'd5, 8'h81, "fifo_order_after_wrap");

    // Asynchronous reset in the middle of a read stream
    host_wr(3'd4, 8'h31);
    host_wr(3'd4, 8'h32);
    host_wr(3'd4, 8'h33);
    i2c_addr_i = 8'h20;
    i2c_rdone_i = 1'b1;
    probe(SRC_I2C, 8'h31, "stream_head");
    #2;
    rst = 1'b1;
    #1;
    i2c_rdone_i = 1'b0;
    tick();
    rst = 1'b0;
    probe(SRC_I2C, 8'hFF, "rst_mid_head");
    probe(SRC_HIRQ, 8'h00, "rst_mid_host_irq");
    probe(SRC_IIRQ, 8'h00, "rst_mid_i2c_irq");
    i2c_addr_i = 8'h21;
    probe(SRC_I2C, 8'h00, "rst_mid_h2i_cnt");
    host_rd(3'd6, 8'h00, "rst_mid_counts");
    host_rd(3'd1, 8'h00, "rst_mid_scratch1");
    host_rd(3'd7, 8'h00, "rst_mid_irq_en");

    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expected responses never observed, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
